// File: rtl/rf_wb_pkg.sv
// Shared constants and the queue entry record for the register-file write-back queue.
package rf_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;
    localparam logic [REG_W-1:0] XZR = 5'd31;

    // The register field is named rd because "reg" is a reserved word.
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/rf_wb_fwd_lookup.sv
// Finds the youngest valid queue entry whose destination matches one read address.
module rf_wb_fwd_lookup
    import rf_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wbq_entry_t        i_entries [DEPTH],
    input  logic [PTR_W-1:0]  i_tail,
    input  logic [REG_W-1:0]  i_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the youngest match is the last one assigned.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PTR_W'(k);
            if (i_entries[w_idx].valid && i_entries[w_idx].rd == i_addr && i_addr != XZR) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// In-order write-back queue feeding the register-file write port, with read forwarding.
// Build with WBQ_COALESCE_EN defined to merge enqueues into an existing pending entry.
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wb_hold,
    output logic              RegWrite,
    output logic [REG_W-1:0]  WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    input  logic [REG_W-1:0]  ReadRegister1,
    input  logic [REG_W-1:0]  ReadRegister2,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [CNT_W-1:0]  count
);

    wbq_entry_t       r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_alloc;
    logic             w_merge;
    logic             w_coal_hit;
    logic [PTR_W-1:0] w_coal_idx;

    assign w_pop  = (r_count != '0) && !wb_hold;
    assign w_full = (r_count == CNT_W'(DEPTH));

`ifdef WBQ_COALESCE_EN
    logic [PTR_W-1:0] w_scan_idx;

    // The head leaving this cycle is excluded so its write is never silently altered.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = '0;
        w_scan_idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_scan_idx = r_tail - PTR_W'(k);
            if (r_entries[w_scan_idx].valid && r_entries[w_scan_idx].rd == in_reg &&
                !(w_pop && w_scan_idx == r_head)) begin
                w_coal_hit = 1'b1;
                w_coal_idx = w_scan_idx;
            end
        end
    end
`else
    assign w_coal_hit = 1'b0;
    assign w_coal_idx = '0;
`endif

    assign in_ready = !rst && (!w_full || w_coal_hit);
    assign w_push   = in_valid && in_ready;
    assign w_alloc  = w_push && (in_reg != XZR) && !w_coal_hit;
    assign w_merge  = w_push && w_coal_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_alloc);
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    // A full queue never allocates, so an allocating slot is never the popping head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc && r_tail == PTR_W'(i)) begin
                    r_entries[i] <= '{valid: 1'b1, rd: in_reg, data: in_data};
                end else if (w_merge && w_coal_idx == PTR_W'(i)) begin
                    r_entries[i].data <= in_data;
                end else if (w_pop && r_head == PTR_W'(i)) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
        end
    end

    assign RegWrite      = w_pop;
    assign WriteRegister = (r_count != '0) ? r_entries[r_head].rd   : '0;
    assign WriteData     = (r_count != '0) ? r_entries[r_head].data : '0;
    assign count         = r_count;

    rf_wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
        .i_entries (r_entries),
        .i_tail    (r_tail),
        .i_addr    (ReadRegister1),
        .o_hit     (fwd_hit1),
        .o_data    (fwd_data1)
    );

    rf_wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
        .i_entries (r_entries),
        .i_tail    (r_tail),
        .i_addr    (ReadRegister2),
        .o_hit     (fwd_hit2),
        .o_data    (fwd_data2)
    );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: queue-based reference model plus directed literal checks.
module tb_rf_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_reg = '0;
    logic [63:0] in_data = '0;
    logic        wb_hold = 1'b0;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic        fwd_hit1;
    logic [63:0] fwd_data1;
    logic        fwd_hit2;
    logic [63:0] fwd_data2;
    logic [2:0]  count;

    always #5 clk = ~clk;

    rf_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .wb_hold       (wb_hold),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .fwd_hit1      (fwd_hit1),
        .fwd_data1     (fwd_data1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data2     (fwd_data2),
        .count         (count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ment_t;

    ment_t mq[$];
    int    checks = 0;
    int    errors = 0;
    bit    cmp_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_pop();
        return (mq.size() != 0) && !wb_hold;
    endfunction

    function automatic bit m_ready();
        if (mq.size() < DEPTH) return 1'b1;
`ifdef WBQ_COALESCE_EN
        for (int i = (m_pop() ? 1 : 0); i < mq.size(); i++)
            if (mq[i].rd == in_reg) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void m_fwd(input logic [4:0] a, output bit hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (a == 5'd31) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == a) begin
                hit = 1'b1;
                d   = mq[i].data;
                return;
            end
        end
    endfunction

    // Reference model: state after each edge, from the handshake and drain rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            bit p, r, merged;
            p = m_pop();
            r = m_ready();
            if (p) void'(mq.pop_front());
            if (in_valid && r && in_reg != 5'd31) begin
                merged = 1'b0;
`ifdef WBQ_COALESCE_EN
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (!merged && mq[i].rd == in_reg) begin
                        mq[i].data = in_data;
                        merged = 1'b1;
                    end
                end
`endif
                if (!merged) mq.push_back('{in_reg, in_data});
            end
        end
    end

    // Compare process: every outputs-meaningful cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            bit          h;
            logic [63:0] d;
            chk("in_ready", in_ready, m_ready());
            chk("RegWrite", RegWrite, m_pop());
            chk("WriteRegister", WriteRegister, (mq.size() != 0) ? mq[0].rd : 5'd0);
            chk("WriteData", WriteData, (mq.size() != 0) ? mq[0].data : 64'd0);
            chk("count", count, mq.size());
            m_fwd(ReadRegister1, h, d);
            chk("fwd_hit1", fwd_hit1, h);
            chk("fwd_data1", fwd_data1, d);
            m_fwd(ReadRegister2, h, d);
            chk("fwd_hit2", fwd_hit2, h);
            chk("fwd_data2", fwd_data2, d);
            if (RegWrite) $display("wb X%0d <= %0h (count %0d)", WriteRegister, WriteData, count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_WriteData", WriteData, 64'd0);
        chk("rst_fwd_hit1", fwd_hit1, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;
        ReadRegister1 = 5'd3;
        #1;
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_RegWrite", RegWrite, 1'b0);
        chk("idle_count", count, 3'd0);
        chk("idle_fwd_hit1", fwd_hit1, 1'b0);

        // Single held entry, forwarded, then drained.
        tick();
        wb_hold = 1'b1; ReadRegister1 = 5'd5;
        in_valid = 1'b1; in_reg = 5'd5; in_data = 64'h1234;
        #1 chk("x5_not_fwd_early", fwd_hit1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("x5_fwd_hit", fwd_hit1, 1'b1);
        chk("x5_fwd_data", fwd_data1, 64'h1234);
        chk("x5_held", RegWrite, 1'b0);
        wb_hold = 1'b0;
        #1;
        chk("x5_wr", RegWrite, 1'b1);
        chk("x5_wreg", WriteRegister, 5'd5);
        chk("x5_wdata", WriteData, 64'h1234);
        tick();
        chk("x5_done_wr", RegWrite, 1'b0);
        chk("x5_done_count", count, 3'd0);

        // XZR handshake allocates nothing.
        in_valid = 1'b1; in_reg = 5'd31; in_data = 64'hDEAD; ReadRegister1 = 5'd31;
        #1 chk("xzr_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("xzr_count", count, 3'd0);
        chk("xzr_wr", RegWrite, 1'b0);
        chk("xzr_fwd", fwd_hit1, 1'b0);

        // Two fill-and-drain bursts; the second wraps the pointers again.
        for (int b = 0; b < 2; b++) begin
            wb_hold = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                in_valid = 1'b1; in_reg = 5'(i); in_data = 64'(i * 'h11);
                tick();
            end
            in_reg = 5'd9; in_data = 64'h99;
            #1;
            chk("full_count", count, 3'd4);
            chk("full_ready", in_ready, 1'b0);
            tick();
            chk("stall_count", count, 3'd4);
            in_valid = 1'b0; wb_hold = 1'b0;
            #1;
            for (int i = 1; i <= 4; i++) begin
                chk("burst_wr", RegWrite, 1'b1);
                chk("burst_wreg", WriteRegister, 5'(i));
                chk("burst_wdata", WriteData, 64'(i * 'h11));
                tick();
            end
            chk("burst_empty", count, 3'd0);
        end

        // Duplicate destination.
        wb_hold = 1'b1; ReadRegister1 = 5'd7;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 64'hA;
        tick();
        in_data = 64'hB;
        tick();
        in_valid = 1'b0;
`ifdef WBQ_COALESCE_EN
        chk("dup_count", count, 3'd1);
`else
        chk("dup_count", count, 3'd2);
`endif
        chk("dup_fwd", fwd_data1, 64'hB);
        wb_hold = 1'b0;
        #1;
`ifndef WBQ_COALESCE_EN
        chk("dup_first", WriteData, 64'hA);
        tick();
`endif
        chk("dup_last", WriteData, 64'hB);
        chk("dup_last_wr", RegWrite, 1'b1);
        tick();
        chk("dup_done", RegWrite, 1'b0);

        // Reset mid-drain.
        wb_hold = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            in_valid = 1'b1; in_reg = 5'(i); in_data = 64'(i);
            tick();
        end
        in_valid = 1'b0; wb_hold = 1'b0;
        #1 chk("pre_rst_wr", RegWrite, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_wr", RegWrite, 1'b0);
        chk("rst_mid_count", count, 3'd0);
        chk("rst_mid_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_wr", RegWrite, 1'b0);
            chk("post_rst_count", count, 3'd0);
            tick();
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 8);
            in_reg = (r == 8) ? 5'd31 : 5'(r);
            in_data = {$urandom, $urandom};
            in_valid = ($urandom_range(0, 9) < 7);
            wb_hold = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 8);
            ReadRegister1 = (r == 8) ? 5'd31 : 5'(r);
            r = $urandom_range(0, 8);
            ReadRegister2 = (r == 8) ? 5'd31 : 5'(r);
            tick();
        end
        in_valid = 1'b0; wb_hold = 1'b0;
        repeat (DEPTH + 2) tick();
        chk("final_empty", count, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
